// File: rtl/song_rom_arbiter.sv
// song_rom_arbiter: shares the single-port song ROM between the note
// shifter (requester 0) and the preview/tone player (requester 1).
// Ports:
//   clk_in, rst_in        clock, async active-high reset
//   reqN/addrN/lockN      read request, address, burst lock of requester N
//   gntN                  one-cycle grant pulse; rom_addr = addrN that cycle
//   rvalidN/rdataN        read return, ROM_LATENCY cycles after gntN
//   rom_addr/rom_data     ROM address (registered) and read data
//   deny_count            saturating count of denied request-cycles
module song_rom_arbiter #(
  parameter int ADDR_BITS   = 10,
  parameter int DATA_BITS   = 8,
  parameter int ROM_LATENCY = 2,
  parameter int MAX_LOCK    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req0,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic                 lock0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [DATA_BITS-1:0] rdata0,
  input  logic                 req1,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic                 lock1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [DATA_BITS-1:0] rdata1,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_BITS-1:0] rom_data,
  output logic [7:0]           deny_count
);

  localparam int LCW =
    (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCW-1:0] LOCK_MAX =
    LCW'(MAX_LOCK - 1);

  logic                   last_grant;
  logic [LCW-1:0]         lock_count;
  logic [ROM_LATENCY-1:0] tag_v;
  logic [ROM_LATENCY-1:0] tag_id;
  logic [ROM_LATENCY-1:0] tag_v_nxt;
  logic [ROM_LATENCY-1:0] tag_id_nxt;

  logic both;
  logic holder_lock;
  logic extend;
  logic pick0;
  logic pick1;
  logic grant;
  logic denied;
  logic ret0;
  logic ret1;

  // Under contention the last winner keeps the port only while it
  // holds its lock and has not used up its burst allowance.
  always_comb begin
    both        = req0 & req1;
    holder_lock = last_grant ? lock1 : lock0;
    extend      = both & holder_lock &
                  (lock_count < LOCK_MAX);
    pick0       = req0;
    pick1       = req1;
    if (both) begin
      pick0 = extend ? ~last_grant : last_grant;
      pick1 = ~pick0;
    end
    grant  = pick0 | pick1;
    denied = (req0 & ~pick0) | (req1 & ~pick1);
  end

  // Tag pipeline: one {valid, id} stage per cycle of ROM latency.
  if (ROM_LATENCY > 1) begin : g_shift
    assign tag_v_nxt  = {tag_v[ROM_LATENCY-2:0], grant};
    assign tag_id_nxt = {tag_id[ROM_LATENCY-2:0], pick1};
  end else begin : g_single
    assign tag_v_nxt  = grant;
    assign tag_id_nxt = pick1;
  end

  assign ret0 = tag_v[ROM_LATENCY-1] &
                ~tag_id[ROM_LATENCY-1];
  assign ret1 = tag_v[ROM_LATENCY-1] &
                tag_id[ROM_LATENCY-1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      rom_addr   <= '0;
      deny_count <= '0;
      last_grant <= 1'b1;
      lock_count <= '0;
      tag_v      <= '0;
      tag_id     <= '0;
    end else begin
      gnt0 <= pick0;
      gnt1 <= pick1;
      if (grant) begin
        rom_addr   <= pick1 ? addr1 : addr0;
        last_grant <= pick1;
        lock_count <= extend ?
                      lock_count + 1'b1 : '0;
      end
      if (denied && deny_count != 8'hFF) begin
        deny_count <= deny_count + 8'd1;
      end
      tag_v   <= tag_v_nxt;
      tag_id  <= tag_id_nxt;
      rvalid0 <= ret0;
      rvalid1 <= ret1;
      if (ret0) begin
        rdata0 <= rom_data;
      end
      if (ret1) begin
        rdata1 <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_song_rom_arbiter.sv
// tb_song_rom_arbiter: scoreboard bench for song_rom_arbiter with a
// 2-cycle ROM model, directed scenarios and randomized traffic.
module tb_song_rom_arbiter;
  localparam int AB = 10;
  localparam int DB = 8;
  localparam int L  = 2;
  localparam int ML = 8;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          req0 = 1'b0;
  logic [AB-1:0] addr0 = '0;
  logic          lock0 = 1'b0;
  logic          gnt0;
  logic          rvalid0;
  logic [DB-1:0] rdata0;
  logic          req1 = 1'b0;
  logic [AB-1:0] addr1 = '0;
  logic          lock1 = 1'b0;
  logic          gnt1;
  logic          rvalid1;
  logic [DB-1:0] rdata1;
  logic [AB-1:0] rom_addr;
  logic [DB-1:0] rom_data;
  logic [7:0]    deny_count;

  logic [DB-1:0] rom [1024];
  logic [DB-1:0] rom_q = '0;

  // Address registered by the DUT, plus one ROM output register.
  always @(posedge clk_in) rom_q <= rom[rom_addr];
  assign rom_data = rom_q;

  song_rom_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .ROM_LATENCY(L), .MAX_LOCK(ML)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0(req0), .addr0(addr0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .deny_count(deny_count)
  );

  always #5 clk_in = ~clk_in;

  int ecount = 0;
  always @(posedge clk_in) ecount <= ecount + 1;

  typedef struct {
    int            id;
    logic [AB-1:0] addr;
    int            stamp;
  } g_t;
  typedef struct {
    int            id;
    logic [DB-1:0] data;
    int            stamp;
  } d_t;

  g_t gq[$];
  d_t dq[$];

  int n_assert = 0;
  int n_fail   = 0;
  int exp_deny = 0;
  int m_deny   = 0;
  int m_last   = 1;
  int m_ext    = 0;
  logic [DB-1:0] hold0 = '0;
  logic [DB-1:0] hold1 = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference: a waiting requester gets the port unless the last
  // winner is locked and has taken fewer than ML-1 extra grants.
  task automatic drive(input logic r0,
                       input logic [AB-1:0] a0,
                       input logic l0,
                       input logic r1,
                       input logic [AB-1:0] a1,
                       input logic l1,
                       output int w);
    g_t g;
    d_t d;
    @(negedge clk_in);
    req0 = r0; addr0 = a0; lock0 = l0;
    req1 = r1; addr1 = a1; lock1 = l1;
    w = -1;
    if (r0 && r1) begin
      if (((m_last == 0) ? l0 : l1) && m_ext < ML - 1) begin
        w = m_last;
        m_ext++;
      end else begin
        w = 1 - m_last;
        m_ext = 0;
      end
    end else if (r0 || r1) begin
      w = r1 ? 1 : 0;
      m_ext = 0;
    end
    if ((r0 && w != 0) || (r1 && w != 1)) begin
      if (m_deny < 255) m_deny++;
    end
    if (w >= 0) begin
      m_last  = w;
      g.id    = w;
      g.addr  = (w == 1) ? a1 : a0;
      g.stamp = ecount + 1;
      gq.push_back(g);
      d.id    = w;
      d.data  = rom[g.addr];
      d.stamp = ecount + 1 + L;
      dq.push_back(d);
    end
    @(posedge clk_in);
    exp_deny = m_deny;
  endtask

  task automatic do_reset();
    #2;
    rst_in = 1'b1;
    gq.delete();
    dq.delete();
    m_last = 1; m_ext = 0; m_deny = 0; exp_deny = 0;
    hold0 = '0; hold1 = '0;
    req0 = 0; lock0 = 0; req1 = 0; lock1 = 0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_deny", deny_count, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Monitor: every grant and return must match the scoreboard head
  // in the exact cycle it was scheduled for.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk("gnt_onehot", gnt0 & gnt1, 0);
      chk("rvalid_onehot", rvalid0 & rvalid1, 0);
      chk("deny_count", deny_count, exp_deny);
      if (gq.size() != 0 && gq[0].stamp == ecount) begin
        g_t g;
        g = gq.pop_front();
        chk("gnt0", gnt0, g.id == 0);
        chk("gnt1", gnt1, g.id == 1);
        chk("rom_addr", rom_addr, g.addr);
      end else begin
        chk("gnt_idle", {gnt0, gnt1}, 0);
      end
      if (dq.size() != 0 && dq[0].stamp == ecount) begin
        d_t d;
        d = dq.pop_front();
        chk("rvalid0", rvalid0, d.id == 0);
        chk("rvalid1", rvalid1, d.id == 1);
        if (d.id == 0) hold0 = d.data;
        else hold1 = d.data;
      end else begin
        chk("rvalid_idle", {rvalid0, rvalid1}, 0);
      end
      chk("rdata0", rdata0, hold0);
      chk("rdata1", rdata1, hold1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int gap;
    int max_gap;
    logic [AB-1:0] a0;
    logic [AB-1:0] a1;
    logic pend0;
    logic pend1;
    logic l0;
    logic l1;
    int p0, p1, pl0, pl1;

    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[250] = 8'hA5;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // First access
    drive(1, 10'd250, 0, 0, 0, 0, w);
    #1;
    chk("first_gnt0", gnt0, 1);
    chk("first_addr", rom_addr, 250);
    drive(0, 0, 0, 0, 0, 0, w);
    #1;
    chk("first_early", rvalid0, 0);
    drive(0, 0, 0, 0, 0, 0, w);
    #1;
    chk("first_rvalid", rvalid0, 1);
    chk("first_rdata", rdata0, 8'hA5);
    drive(0, 0, 0, 0, 0, 0, w);
    #1;
    chk("first_pulse", rvalid0, 0);
    do_reset();

    // Streaming
    for (int k = 0; k < 9; k++) begin
      drive(k < 5, AB'(k), 0, 0, 0, 0, w);
      #1;
      if (k < 5) chk("stream_gnt0", gnt0, 1);
      chk("stream_rvalid0", rvalid0, k >= 2 && k <= 6);
      if (k >= 2 && k <= 6)
        chk("stream_rdata0", rdata0, rom[k-2]);
    end
    chk("stream_deny", deny_count, 0);
    do_reset();

    // Contention without lock
    a0 = 10'd17; a1 = 10'd900;
    for (int k = 0; k < 6; k++) begin
      drive(1, a0, 0, 1, a1, 0, w);
      #1;
      chk("cont_gnt0", gnt0, (k % 2) == 0);
      chk("cont_gnt1", gnt1, (k % 2) == 1);
      if (w == 0) a0 = a0 + 10'd3;
      if (w == 1) a1 = a1 + 10'd5;
    end
    chk("cont_deny", deny_count, 6);
    repeat (L + 1) drive(0, 0, 0, 0, 0, 0, w);
    do_reset();

    // Lock bound
    for (int k = 0; k < 18; k++) begin
      drive(1, a0, 1, 1, a1, 0, w);
      #1;
      chk("lock_gnt0", gnt0, !(k == 8 || k == 17));
      chk("lock_gnt1", gnt1, k == 8 || k == 17);
      if (w == 0) a0 = a0 + 10'd1;
      if (w == 1) a1 = a1 + 10'd1;
    end
    repeat (L + 1) drive(0, 0, 0, 0, 0, 0, w);
    do_reset();

    // Reset mid-flight
    drive(1, 10'd5, 0, 1, 10'd6, 0, w);
    drive(0, 10'd0, 0, 1, 10'd6, 0, w);
    drive(0, 0, 0, 0, 0, 0, w);
    do_reset();
    for (int k = 0; k < L + 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, w);
      #1;
      chk("flight_quiet", {rvalid0, rvalid1}, 0);
    end
    do_reset();

    // Saturation under a continuous lock
    gap = 0; max_gap = 0;
    for (int k = 0; k < 600; k++) begin
      drive(1, a0, 1, 1, a1, 0, w);
      #1;
      if (gnt1) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      if (w == 0) a0 = a0 + 10'd7;
      if (w == 1) a1 = a1 + 10'd11;
    end
    chk("sat_deny", deny_count, 255);
    chk("sat_gap", max_gap <= ML, 1);
    repeat (L + 1) drive(0, 0, 0, 0, 0, 0, w);
    do_reset();

    // Randomized traffic
    pend0 = 0; pend1 = 0;
    for (int ph = 0; ph < 8; ph++) begin
      p0  = $urandom_range(1, 10);
      p1  = $urandom_range(1, 10);
      pl0 = $urandom_range(0, 10);
      pl1 = $urandom_range(0, 10);
      for (int k = 0; k < 300; k++) begin
        if (!pend0 && $urandom_range(0, 9) < p0) begin
          pend0 = 1; a0 = AB'($urandom);
        end
        if (!pend1 && $urandom_range(0, 9) < p1) begin
          pend1 = 1; a1 = AB'($urandom);
        end
        l0 = $urandom_range(0, 9) < pl0;
        l1 = $urandom_range(0, 9) < pl1;
        drive(pend0, pend0 ? a0 : AB'($urandom), l0,
              pend1, pend1 ? a1 : AB'($urandom), l1, w);
        if (w == 0) pend0 = 0;
        if (w == 1) pend1 = 0;
      end
    end

    repeat (L + 3) drive(0, 0, 0, 0, 0, 0, w);
    chk("gq_drained", gq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
